// File: rtl/c_sched.sv
// c_sched: round-robin scheduler sharing block c between requesters a and b.
// A grant issues one start to c, then waits for c_ack or a timeout and
// returns a done (plus err on timeout) pulse to the granted requester.
//
// state | meaning
// IDLE  | no transaction; c_sel/c_data held at 0
// GRANT | one cycle: owner's gnt and c_start asserted, timeout counter cleared
// WAIT  | waiting for c_ack, counting towards TIMEOUT
// DONE  | one cycle: owner's done asserted, err reflects timeout
module c_sched #(
  parameter int A_W     = 2,
  parameter int B_W     = 6,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           a_req,
  input  logic [A_W-1:0] a_data,
  output logic           a_gnt,
  output logic           a_done,
  input  logic           b_req,
  input  logic [B_W-1:0] b_data,
  output logic           b_gnt,
  output logic           b_done,
  output logic           c_start,
  output logic           c_sel,
  output logic [B_W-1:0] c_data,
  input  logic           c_ack,
  output logic           err,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic            err_flag_q, err_flag_d;
  logic            c_sel_q, c_sel_d;
  logic [B_W-1:0]  c_data_q, c_data_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  // State and datapath registers; last_owner resets to b so a wins first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      err_flag_q   <= 1'b0;
      c_sel_q      <= 1'b0;
      c_data_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      err_flag_q   <= err_flag_d;
      c_sel_q      <= c_sel_d;
      c_data_q     <= c_data_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic: arbitration in IDLE, timeout/ack resolution in WAIT.
  // c_sel/c_data are loaded on the IDLE->GRANT edge so they are already
  // valid in the grant cycle without a combinational path from the inputs.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    err_flag_d   = err_flag_q;
    c_sel_d      = c_sel_q;
    c_data_d     = c_data_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_d  = (a_req && b_req) ? ~last_owner_q : b_req;
          c_sel_d  = owner_d;
          c_data_d = owner_d ? b_data : B_W'(a_data);
          state_d  = GRANT;
        end
      end
      GRANT: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (c_ack) begin
          err_flag_d = 1'b0;
          state_d    = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_flag_d = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        c_sel_d      = 1'b0;
        c_data_d     = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_gnt   = (state_q == GRANT) && !owner_q;
  assign b_gnt   = (state_q == GRANT) &&  owner_q;
  assign c_start = (state_q == GRANT);
  assign a_done  = (state_q == DONE)  && !owner_q;
  assign b_done  = (state_q == DONE)  &&  owner_q;
  assign err     = (state_q == DONE)  &&  err_flag_q;
  assign busy    = (state_q != IDLE);
  assign c_sel   = c_sel_q;
  assign c_data  = c_data_q;

endmodule

// File: tb/tb_c_sched.sv
// tb_c_sched: directed scenarios plus random traffic, every cycle's outputs
// compared against a transaction-timeline model of the scheduler.
module tb_c_sched;
  localparam int A_W = 2, B_W = 6, TIMEOUT = 16, TO_W = 5;

  logic           clk = 1'b0;
  logic           rst, a_req, b_req, c_ack;
  logic [A_W-1:0] a_data;
  logic [B_W-1:0] b_data;
  logic           a_gnt, a_done, b_gnt, b_done, c_start, c_sel, err, busy;
  logic [B_W-1:0] c_data;

  int n_chk = 0, n_err = 0, cyc = 0;

  // model: m_k = cycles since the request was seen (0 = no transaction)
  int             m_k;
  bit             m_done, m_err, m_owner, m_last;
  logic [B_W-1:0] m_data;

  c_sched #(.A_W(A_W), .B_W(B_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_data(a_data), .a_gnt(a_gnt), .a_done(a_done),
    .b_req(b_req), .b_data(b_data), .b_gnt(b_gnt), .b_done(b_done),
    .c_start(c_start), .c_sel(c_sel), .c_data(c_data), .c_ack(c_ack),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return 32'({a_gnt, a_done, b_gnt, b_done, c_start, c_sel, c_data, err, busy});
  endfunction

  function automatic logic [31:0] exp_vec();
    logic ag = 0, ad = 0, bg = 0, bd = 0, cs = 0, sel = 0, er = 0, bz = 0;
    logic [B_W-1:0] d = '0;
    if (m_k != 0) begin
      bz = 1; sel = m_owner; d = m_data;
      if (m_k == 1) begin cs = 1; if (m_owner) bg = 1; else ag = 1; end
      if (m_done) begin er = m_err; if (m_owner) bd = 1; else ad = 1; end
    end
    return 32'({ag, ad, bg, bd, cs, sel, d, er, bz});
  endfunction

  // advance the model by one cycle using the inputs applied this cycle
  task automatic model_step();
    if (rst) begin
      m_k = 0; m_done = 0; m_last = 1;
    end else if (m_k == 0) begin
      if (a_req || b_req) begin
        m_owner = (a_req && b_req) ? !m_last : b_req;
        m_data  = m_owner ? b_data : {{(B_W-A_W){1'b0}}, a_data};
        m_k     = 1;
      end
    end else if (m_done) begin
      m_last = m_owner; m_k = 0; m_done = 0;
    end else begin
      // wait cycles are m_k = 2 .. TIMEOUT+1; the last one aborts without ack
      if (m_k >= 2) begin
        if (c_ack) begin m_done = 1; m_err = 0; end
        else if (m_k == TIMEOUT + 1) begin m_done = 1; m_err = 1; end
      end
      m_k++;
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    check("outs", obs_vec(), exp_vec());
  endtask

  initial begin
    int g, ngnt, last_g;
    bit prev_gnt;
    rst = 1; a_req = 0; b_req = 0; c_ack = 0; a_data = '0; b_data = '0;
    m_k = 0; m_done = 0; m_err = 0; m_owner = 0; m_last = 1; m_data = '0;
    tick(); tick();
    check("reset", obs_vec(), 32'd0);
    rst = 0;

    // single a transaction, ack in the second wait cycle
    a_req = 1; a_data = 2'b11;
    tick();
    check("a_grant", 32'({a_gnt, c_start, c_sel, c_data}), 32'({3'b110, 6'h03}));
    a_req = 0;
    tick();
    tick(); c_ack = 1;
    tick(); c_ack = 0;
    check("a_done", 32'({a_done, err}), 32'b10);
    tick();
    check("a_idle", 32'(busy), 32'd0);

    // contention from reset: a,b,a,b with 4 cycles between grants
    rst = 1; a_req = 1; b_req = 1; a_data = 2'b01; b_data = 6'h15;
    tick(); rst = 0;
    ngnt = 0; last_g = 0; prev_gnt = 0;
    for (int i = 0; i < 40 && ngnt < 4; i++) begin
      tick();
      c_ack = prev_gnt;
      prev_gnt = a_gnt | b_gnt;
      if (a_gnt | b_gnt) begin
        if (ngnt > 0) check("rr_gap", 32'(cyc - last_g), 32'd4);
        check("rr_sel", 32'(c_sel), 32'(ngnt % 2));
        last_g = cyc; ngnt++;
      end
    end
    check("rr_count", 32'(ngnt), 32'd4);
    tick(); c_ack = 0; a_req = 0; b_req = 0;
    repeat (4) tick();

    // b timeout: done+err 18 cycles after the request cycle
    rst = 1; tick(); rst = 0;
    b_req = 1; b_data = 6'h2A;
    tick();
    check("to_gnt", 32'(b_gnt), 32'd1);
    g = cyc; b_req = 0;
    repeat (16) tick();
    tick();
    check("to_done", 32'({b_done, err, 5'(cyc - g)}), 32'({2'b11, 5'd17}));
    tick();
    check("to_idle", 32'(busy), 32'd0);

    // ack on the final wait count: ack wins
    a_req = 1; a_data = 2'b01;
    tick(); a_req = 0;
    repeat (TIMEOUT) tick();
    c_ack = 1;
    tick(); c_ack = 0;
    check("edge_ack", 32'({a_done, err}), 32'b10);
    tick();

    // ack in IDLE and in GRANT is ignored
    c_ack = 1; tick(); tick();
    check("ack_idle", 32'(busy), 32'd0);
    a_req = 1; tick();           // request cycle carries an ack too
    a_req = 0; tick();           // ack during grant
    c_ack = 0;
    check("ack_grant", 32'({busy, a_done}), 32'b10);
    c_ack = 1; tick(); c_ack = 0; tick(); tick();

    // reset mid-wait with b owning c
    b_req = 1; b_data = 6'h3C; tick(); b_req = 0;
    repeat (3) tick();
    check("mid_sel", 32'(c_sel), 32'd1);
    rst = 1; tick(); rst = 0;
    check("rst_all", obs_vec(), 32'd0);
    a_req = 1; b_req = 1; tick();
    check("post_rst_a", 32'({a_gnt, b_gnt}), 32'b10);
    a_req = 0; b_req = 0;

    // random traffic obeying the hold-until-grant protocol
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (a_req && a_gnt) a_req = ($urandom_range(0, 3) == 0);
      else if (!a_req && $urandom_range(0, 3) == 0) begin a_req = 1; a_data = A_W'($urandom); end
      if (b_req && b_gnt) b_req = ($urandom_range(0, 3) == 0);
      else if (!b_req && $urandom_range(0, 3) == 0) begin b_req = 1; b_data = B_W'($urandom); end
      c_ack = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
